// File: rtl/csa_stream_accumulator.sv
// csa_stream_accumulator
// Accumulates a stream of signed operands in carry-save form (S, C) with no
// carry propagation on the accumulate path. On the last operand of a packet
// the redundant pair is resolved SEG bits per cycle, LSB segment first, and
// the binary result is offered on a valid/ready output port.

module csa_stream_accumulator #(
  parameter int N     = 32,
  parameter int GUARD = 8,
  parameter int SEG   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N+GUARD-1:0]   out_sum,
  output logic                 out_overflow
);

  localparam int W    = N + GUARD;
  localparam int NSEG = W / SEG;
  localparam int IDXW = $clog2(NSEG + 1);
  localparam int CW   = GUARD + 2;

  localparam logic [CW-1:0]   CNT_LIM  = CW'(1 << GUARD);
  localparam logic [CW-1:0]   CNT_SAT  = CW'((1 << GUARD) + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSEG - 1);

  // The segmented resolver needs the accumulator to split into whole segments
  generate
    if ((W % SEG) != 0) begin : g_bad_seg
      $error("csa_stream_accumulator: N+GUARD must be a multiple of SEG");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  state_t          state;
  logic [W-1:0]    s_reg;
  logic [W-1:0]    c_reg;
  logic [W-1:0]    res;
  logic [CW-1:0]   count;
  logic [IDXW-1:0] seg_idx;
  logic            carry_r;

  logic            accept;
  logic [W-1:0]    x_ext;
  logic [W-1:0]    s_next;
  logic [W-1:0]    c_next;
  logic [31:0]     seg_lo;
  logic [SEG:0]    seg_sum;
  logic [W-1:0]    res_next;
  logic            last_seg;
  logic            handshake;

  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;
  assign last_seg  = (seg_idx == LAST_IDX);

  // One full-adder level: sign-extend the operand and fold it into (S, C)
  always_comb begin
    x_ext  = {{GUARD{in_data[N-1]}}, in_data};
    s_next = s_reg ^ c_reg ^ x_ext;
    c_next = ((s_reg & c_reg) | (s_reg & x_ext) | (c_reg & x_ext)) << 1;
  end

  // Add the current segment of S and C with the carry from the segment below
  always_comb begin
    seg_lo   = 32'(seg_idx) * 32'(SEG);
    seg_sum  = {1'b0, s_reg[seg_lo +: SEG]} + {1'b0, c_reg[seg_lo +: SEG]}
             + {{SEG{1'b0}}, carry_r};
    res_next = res;
    res_next[seg_lo +: SEG] = seg_sum[SEG-1:0];
  end

  // Packet state machine with accumulate, resolve and output handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      s_reg        <= '0;
      c_reg        <= '0;
      res          <= '0;
      count        <= '0;
      seg_idx      <= '0;
      carry_r      <= 1'b0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          in_ready <= 1'b1;
          if (accept) begin
            s_reg <= s_next;
            c_reg <= c_next;
            if (count != CNT_SAT) begin
              count <= count + CW'(1);
            end
            if (in_last) begin
              state    <= RESOLVE;
              in_ready <= 1'b0;
              seg_idx  <= '0;
              carry_r  <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end

        RESOLVE: begin
          res     <= res_next;
          carry_r <= seg_sum[SEG];
          seg_idx <= seg_idx + IDXW'(1);
          if (last_seg) begin
            state        <= OUTPUT;
            out_valid    <= 1'b1;
            out_sum      <= res_next;
            out_overflow <= (count > CNT_LIM);
          end
        end

        OUTPUT: begin
          if (handshake) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            s_reg     <= '0;
            c_reg     <= '0;
            count     <= '0;
            seg_idx   <= '0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/csa_stream_accumulator.md
Name: csa_stream_accumulator

Overview:
Sequential successor to the combinational carry-save adder. It accumulates a stream of signed N-bit operands in redundant carry-save form, one operand per cycle, with no carry propagation on the accumulate path. On the last operand of a packet, it resolves the redundant pair to a binary result with a segmented carry-propagate adder over several cycles, then presents the result on a valid/ready output. It sits between a sample source and any consumer that needs long signed sums, such as dot products or filter taps.

Parameters:
N, 32, input operand width (signed two's complement)
GUARD, 8, extra accumulator bits; accumulator width W = N+GUARD
SEG, 8, bits resolved per cycle by the final CPA; W must be a multiple of SEG (elaboration error otherwise)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand valid
in_ready  output  1  block can accept an operand this cycle
in_data  input  N  signed operand
in_last  input  1  marks the final operand of a packet; qualified by in_valid && in_ready
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_sum  output  W  signed packet sum, modulo 2^W
out_overflow  output  1  packet had more than 2^GUARD operands; the sum may have wrapped

Behaviour:
- Interface decision: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values: in_ready=0 while rst is high, then 1 from the first cycle after release. out_valid=0, out_sum=0, out_overflow=0. State=IDLE. Registers S, C, count, seg_idx and carry_r are all 0.
- States:
  - IDLE: no packet open. in_ready=1.
  - ACCUM: packet open. in_ready=1.
  - RESOLVE: in_ready=0.
  - OUTPUT: in_ready=0, out_valid=1.
- Accept condition: in_valid && in_ready. On accept, X = sign-extend(in_data) to W bits and:
  - S <= S ^ C ^ X
  - C <= ((S&C)|(S&X)|(C&X)) << 1, truncated to W bits
  - The invariant (S + C) mod 2^W equals the running sum.
  - count <= count+1, saturating at 2^GUARD+1.
- Transitions:
  - IDLE or ACCUM, accept with in_last=0 -> ACCUM.
  - IDLE or ACCUM, accept with in_last=1 -> RESOLVE. A single-operand packet is legal.
  - No accept -> state unchanged. in_valid=0 mid-packet is legal and the packet stays open.
- RESOLVE: runs exactly W/SEG cycles, for seg_idx = 0..W/SEG-1, LSB segment first.
  - Each cycle: {carry_r, res[seg]} <= S[seg] + C[seg] + carry_r.
  - carry_r is cleared when RESOLVE is entered.
  - On the final segment -> OUTPUT. out_sum <= res. out_overflow <= (count > 2^GUARD).
- Latency: last operand accepted in cycle t -> out_valid first high in cycle t+1+W/SEG.
- OUTPUT:
  - out_valid, out_sum and out_overflow are held stable until out_ready=1.
  - On out_valid && out_ready: clear S, C, count and seg_idx. out_valid drops the next cycle. State -> IDLE.
  - out_sum keeps its last value until the next result is produced.
- Backpressure: input is not accepted during RESOLVE or OUTPUT. Operands presented then must be held by the source; none are dropped or merged.
- Wrap-around: the sum is exact for up to 2^GUARD operands. Beyond that, out_sum is the sum mod 2^W and out_overflow=1. The carry out of the top segment is discarded.
- Reset mid-operation: asserting rst in any state immediately (asynchronously) forces IDLE and the reset values. A partial packet or pending result is discarded.
- Resolution timing: S and C are never resolved in the accumulate cycle. The accumulate path is a single full-adder level plus a shift.

Test Plan:
Settings for all scenarios: N=8, GUARD=8, SEG=4, so W=16 and RESOLVE takes 4 cycles.
1. Single operand: rst pulse, then in_data=8'h7F with in_last=1 at cycle t -> out_sum=16'h007F, out_overflow=0, out_valid at t+5, in_ready=0 for t+1..t+5.
2. Mixed signs: in_data = 100, -50, -128, 127 (last) back-to-back -> out_sum=16'h0031 (49); then 3 negatives -128 x3 -> 16'hFE80 (-384).
3. Bubbles and backpressure: valid gaps between operands 1,2,3 (last); hold out_ready=0 for 6 cycles -> out_sum=6 stable, out_valid held; input stalled; next packet 5 (last) accepted only after the handshake, giving out_sum=5.
4. Overflow: 257 operands of 8'h7F -> out_overflow=1, out_sum=(257*127) mod 65536=16'h7F7F. A following packet of 256 x 8'h80 -> out_sum=16'h8000 (-32768), out_overflow=0.
5. Reset mid-RESOLVE: packet 10,20 (last), assert rst at 2nd RESOLVE cycle -> outputs reset immediately. Next packet 7 (last) -> out_sum=7 with no residue.
6. Random regression: 10k random packets of length 1..300 with random valid and out_ready; compare against a golden mod-2^16 sum and count>256 overflow flag.
